multi_port_register_file: RTL and testbench

- Parametrised successor to the single-cycle MIPS register file: N asynchronous read ports, M clocked write ports, optional write-to-read bypass and hardwired zero register.
- Adds an asynchronous reset that clears all registers.
- Adds a per-register scoreboard (busy bits) so the pipelined datapath can detect RAW hazards.
- Sits between decode (reads, reserve) and writeback (writes).

---
 rtl/register_file_pkg.sv | 32 +++
 rtl/register_scoreboard.sv | 49 ++++
 rtl/multi_port_register_file.sv | 106 ++++++++++
 tb/tb_multi_port_register_file.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared definitions for the multi-port register file.
// Contents:
//   clog2 / index_width : constant functions for sizing register index fields
//   ZERO_REGISTER_INDEX : index of the hardwired-zero register
//   DEFAULT_*           : classic MIPS configuration (32 x 32 bit, 2 read / 1 write)
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH       = 32;
  localparam int DEFAULT_REGISTER_COUNT   = 32;
  localparam int DEFAULT_READ_PORT_COUNT  = 2;
  localparam int DEFAULT_WRITE_PORT_COUNT = 1;

  localparam int ZERO_REGISTER_INDEX = 0;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  // Never returns zero, so a one-register file still gets a legal index field.
  function automatic int index_width(input int register_count);
    return (register_count > 1) ? clog2(register_count) : 1;
  endfunction

endpackage

// File: rtl/register_scoreboard.sv
// Per-register busy bits used by the pipeline to detect RAW hazards.
// Ports:
//   clock                  : rising-edge clock
//   reset_n                : asynchronous active-low reset, clears every busy bit
//   reserve_signal         : claim reserve_register_index for an issuing instruction
//   reserve_register_index : register being claimed
//   clear_mask             : one bit per register written this cycle
//   busy                   : registered busy bit per register
module register_scoreboard
  import register_file_pkg::*;
#(
  parameter int REGISTER_COUNT       = DEFAULT_REGISTER_COUNT,
  parameter int ZERO_REGISTER_ENABLE = 1,
  localparam int INDEX_WIDTH         = index_width(REGISTER_COUNT)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      reserve_signal,
  input  logic [INDEX_WIDTH-1:0]    reserve_register_index,
  input  logic [REGISTER_COUNT-1:0] clear_mask,
  output logic [REGISTER_COUNT-1:0] busy
);

  logic [REGISTER_COUNT-1:0] set_mask;

  // NOTE: every variable written in an always_comb gets a default first;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    set_mask = '0;
    if (reserve_signal &&
        !(ZERO_REGISTER_ENABLE != 0 &&
          reserve_register_index == INDEX_WIDTH'(ZERO_REGISTER_INDEX))) begin
      set_mask[reserve_register_index] = 1'b1;
    end
  end

  // Set is applied after clear: a reserve in the same cycle as the write that
  // retires the previous producer leaves the register owned by the new one.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= set_mask | (busy & ~clear_mask);
    end
  end

endmodule

// File: rtl/multi_port_register_file.sv
// Parametrised register file with N combinational read ports, M clocked
// write ports, optional write-to-read bypass, optional hardwired zero
// register and a RAW-hazard scoreboard.
// Ports:
//   clock, reset_n         : rising-edge clock, asynchronous active-low reset
//   read_register_index    : READ_PORT_COUNT packed indices, port p at [p*IW +: IW]
//   read_data              : READ_PORT_COUNT packed data words
//   read_busy              : registered busy bit of each read index
//   write_register_index   : WRITE_PORT_COUNT packed indices
//   write_data             : WRITE_PORT_COUNT packed data words
//   write_signal           : per-write-port enable
//   reserve_signal         : mark reserve_register_index busy
//   reserve_register_index : register claimed by the issuing instruction
module multi_port_register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
  parameter int REGISTER_COUNT       = DEFAULT_REGISTER_COUNT,
  parameter int READ_PORT_COUNT      = DEFAULT_READ_PORT_COUNT,
  parameter int WRITE_PORT_COUNT     = 2,
  parameter int BYPASS_ENABLE        = 1,
  parameter int ZERO_REGISTER_ENABLE = 1,
  localparam int INDEX_WIDTH         = index_width(REGISTER_COUNT)
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic [READ_PORT_COUNT*INDEX_WIDTH-1:0] read_register_index,
  output logic [READ_PORT_COUNT*DATA_WIDTH-1:0]  read_data,
  output logic [READ_PORT_COUNT-1:0]             read_busy,
  input  logic [WRITE_PORT_COUNT*INDEX_WIDTH-1:0] write_register_index,
  input  logic [WRITE_PORT_COUNT*DATA_WIDTH-1:0] write_data,
  input  logic [WRITE_PORT_COUNT-1:0]            write_signal,
  input  logic                                   reserve_signal,
  input  logic [INDEX_WIDTH-1:0]                 reserve_register_index
);

  logic [DATA_WIDTH-1:0]     storage     [REGISTER_COUNT];
  logic [DATA_WIDTH-1:0]     write_value [REGISTER_COUNT];
  logic [REGISTER_COUNT-1:0] write_hit;
  logic [REGISTER_COUNT-1:0] busy;
  logic [INDEX_WIDTH-1:0]    write_index [WRITE_PORT_COUNT];

  for (genvar w = 0; w < WRITE_PORT_COUNT; w++) begin : g_write_index
    assign write_index[w] = write_register_index[w*INDEX_WIDTH +: INDEX_WIDTH];
  end

  // Resolve the write ports into one candidate per register. Ports are walked
  // in ascending order so the highest-numbered colliding port overrides the
  // rest. Gating with reset_n keeps bypass and scoreboard clears quiet while
  // the file is held in reset.
  always_comb begin
    write_hit = '0;
    for (int r = 0; r < REGISTER_COUNT; r++) begin
      write_value[r] = '0;
    end
    for (int w = 0; w < WRITE_PORT_COUNT; w++) begin
      if (reset_n && write_signal[w] &&
          !(ZERO_REGISTER_ENABLE != 0 &&
            write_index[w] == INDEX_WIDTH'(ZERO_REGISTER_INDEX))) begin
        write_hit[write_index[w]]   = 1'b1;
        write_value[write_index[w]] = write_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // NOTE: the array is built from flops, not an SRAM macro, so it can take the
  // asynchronous clear; a RAM-inferred file would have to drop this reset.
  // With the zero register enabled, entry 0 is never written and stays at its
  // reset value, so it reads as zero without a separate mux.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < REGISTER_COUNT; r++) begin
        storage[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REGISTER_COUNT; r++) begin
        if (write_hit[r]) begin
          storage[r] <= write_value[r];
        end
      end
    end
  end

  register_scoreboard #(
    .REGISTER_COUNT      (REGISTER_COUNT),
    .ZERO_REGISTER_ENABLE(ZERO_REGISTER_ENABLE)
  ) u_scoreboard (
    .clock                 (clock),
    .reset_n               (reset_n),
    .reserve_signal        (reserve_signal),
    .reserve_register_index(reserve_register_index),
    .clear_mask            (write_hit),
    .busy                  (busy)
  );

  // read_busy reflects registered state only: neither a same-cycle write nor
  // a same-cycle reserve is forwarded into it.
  for (genvar p = 0; p < READ_PORT_COUNT; p++) begin : g_read
    logic [INDEX_WIDTH-1:0] index;
    assign index = read_register_index[p*INDEX_WIDTH +: INDEX_WIDTH];
    assign read_data[p*DATA_WIDTH +: DATA_WIDTH] =
      (BYPASS_ENABLE != 0 && write_hit[index]) ? write_value[index] : storage[index];
    assign read_busy[p] = busy[index];
  end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Bench for multi_port_register_file. Two instances share all inputs: one with
// bypass enabled, one without. Stimulus pushes expected read results tagged
// with the cycle they belong to; a monitor on the falling edge pops and
// compares them.
module tb_multi_port_register_file;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int RP = 2;
  localparam int WP = 2;
  localparam int IW = 5;

  typedef struct {
    int          cycle;
    string       name;
    bit          no_bypass;
    int          port;
    logic [31:0] data;
    logic        busy;
  } expect_t;

  expect_t exp_q[$];

  logic           clock = 1'b0;
  logic           reset_n;
  logic [RP*IW-1:0] read_register_index;
  logic [RP*DW-1:0] read_data_bp;
  logic [RP*DW-1:0] read_data_nb;
  logic [RP-1:0]    read_busy_bp;
  logic [RP-1:0]    read_busy_nb;
  logic [WP*IW-1:0] write_register_index;
  logic [WP*DW-1:0] write_data;
  logic [WP-1:0]    write_signal;
  logic             reserve_signal;
  logic [IW-1:0]    reserve_register_index;

  int cycle_count = 0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cycle_count <= cycle_count + 1;

  multi_port_register_file #(
    .DATA_WIDTH(DW), .REGISTER_COUNT(RC), .READ_PORT_COUNT(RP),
    .WRITE_PORT_COUNT(WP), .BYPASS_ENABLE(1), .ZERO_REGISTER_ENABLE(1)
  ) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .read_register_index   (read_register_index),
    .read_data             (read_data_bp),
    .read_busy             (read_busy_bp),
    .write_register_index  (write_register_index),
    .write_data            (write_data),
    .write_signal          (write_signal),
    .reserve_signal        (reserve_signal),
    .reserve_register_index(reserve_register_index)
  );

  multi_port_register_file #(
    .DATA_WIDTH(DW), .REGISTER_COUNT(RC), .READ_PORT_COUNT(RP),
    .WRITE_PORT_COUNT(WP), .BYPASS_ENABLE(0), .ZERO_REGISTER_ENABLE(1)
  ) dut_nb (
    .clock                 (clock),
    .reset_n               (reset_n),
    .read_register_index   (read_register_index),
    .read_data             (read_data_nb),
    .read_busy             (read_busy_nb),
    .write_register_index  (write_register_index),
    .write_data            (write_data),
    .write_signal          (write_signal),
    .reserve_signal        (reserve_signal),
    .reserve_register_index(reserve_register_index)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: compare every expectation belonging to the current cycle.
  always @(negedge clock) begin : monitor
    expect_t     e;
    logic [31:0] got_data;
    logic        got_busy;
    while (exp_q.size() > 0 && exp_q[0].cycle <= cycle_count) begin
      e = exp_q.pop_front();
      if (e.cycle < cycle_count) begin
        checks++;
        errors++;
        $display("FAIL %s: sampled in cycle %0d, expected cycle %0d", e.name, cycle_count, e.cycle);
      end else begin
        got_data = e.no_bypass ? read_data_nb[e.port*DW +: DW] : read_data_bp[e.port*DW +: DW];
        got_busy = e.no_bypass ? read_busy_nb[e.port] : read_busy_bp[e.port];
        check({e.name, "_data"}, got_data, e.data);
        check({e.name, "_busy"}, {31'b0, got_busy}, {31'b0, e.busy});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_signal   = '0;
    reserve_signal = 1'b0;
  endtask

  task automatic set_reads(input int i0, input int i1);
    read_register_index[0*IW +: IW] = IW'(i0);
    read_register_index[1*IW +: IW] = IW'(i1);
  endtask

  task automatic set_write(input int port, input int index, input logic [31:0] data);
    write_signal[port]                = 1'b1;
    write_register_index[port*IW +: IW] = IW'(index);
    write_data[port*DW +: DW]           = data;
  endtask

  task automatic reserve(input int index);
    reserve_signal         = 1'b1;
    reserve_register_index = IW'(index);
  endtask

  task automatic expect_read(input string name, input bit no_bypass, input int port,
                             input logic [31:0] data, input logic busy);
    expect_t e;
    e.cycle     = cycle_count;
    e.name      = name;
    e.no_bypass = no_bypass;
    e.port      = port;
    e.data      = data;
    e.busy      = busy;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n                = 1'b0;
    read_register_index    = '0;
    write_register_index   = '0;
    write_data             = '0;
    reserve_register_index = '0;
    idle();
    step();

    // Reset held with a live write and reserve: nothing lands, bypass suppressed.
    set_write(0, 3, 32'd333);
    reserve(3);
    set_reads(3, 3);
    expect_read("reset_hold_bp", 0, 0, 32'd0, 1'b0);
    expect_read("reset_hold_nb", 1, 1, 32'd0, 1'b0);
    step();
    expect_read("reset_hold2_bp", 0, 1, 32'd0, 1'b0);
    step();
    reset_n = 1'b1;
    idle();
    expect_read("after_reset_bp", 0, 0, 32'd0, 1'b0);
    expect_read("after_reset_nb", 1, 1, 32'd0, 1'b0);

    // Basic write then read.
    step();
    set_write(0, 3, 32'd333);
    set_reads(3, 3);
    expect_read("basic_same_nb_p0", 1, 0, 32'd0, 1'b0);
    expect_read("basic_same_nb_p1", 1, 1, 32'd0, 1'b0);
    expect_read("basic_bypass_bp", 0, 0, 32'd333, 1'b0);
    step();
    idle();
    expect_read("basic_next_nb_p0", 1, 0, 32'd333, 1'b0);
    expect_read("basic_next_nb_p1", 1, 1, 32'd333, 1'b0);

    // Zero register: write and reserve are both ignored.
    step();
    set_write(0, 0, 32'd333);
    reserve(0);
    set_reads(0, 0);
    expect_read("zero_same_bp", 0, 0, 32'd0, 1'b0);
    step();
    idle();
    expect_read("zero_next_bp", 0, 0, 32'd0, 1'b0);
    expect_read("zero_next_nb", 1, 1, 32'd0, 1'b0);

    // Write collision: port 1 wins, both for bypass and for storage.
    step();
    set_write(0, 5, 32'h11);
    set_write(1, 5, 32'h22);
    set_reads(5, 5);
    expect_read("collide_bypass_p0", 0, 0, 32'h22, 1'b0);
    expect_read("collide_bypass_p1", 0, 1, 32'h22, 1'b0);
    expect_read("collide_same_nb", 1, 0, 32'd0, 1'b0);
    step();
    idle();
    expect_read("collide_next_nb", 1, 0, 32'h22, 1'b0);
    expect_read("collide_next_bp", 0, 1, 32'h22, 1'b0);

    // Two ports writing different registers in one cycle.
    step();
    set_write(0, 9, 32'hAAAA);
    set_write(1, 10, 32'hBBBB);
    set_reads(9, 10);
    expect_read("dual_bypass_p0", 0, 0, 32'hAAAA, 1'b0);
    expect_read("dual_bypass_p1", 0, 1, 32'hBBBB, 1'b0);
    step();
    idle();
    expect_read("dual_next_nb_p0", 1, 0, 32'hAAAA, 1'b0);
    expect_read("dual_next_nb_p1", 1, 1, 32'hBBBB, 1'b0);

    // Scoreboard: reserve, then write, then simultaneous reserve and write.
    step();
    reserve(7);
    set_reads(7, 3);
    expect_read("sb_reserve_same", 0, 0, 32'd0, 1'b0);
    step();
    idle();
    expect_read("sb_reserve_next", 0, 0, 32'd0, 1'b1);
    expect_read("sb_other_reg", 0, 1, 32'd333, 1'b0);
    step();
    set_write(0, 7, 32'h77);
    expect_read("sb_write_same_bp", 0, 0, 32'h77, 1'b1);
    expect_read("sb_write_same_nb", 1, 0, 32'd0, 1'b1);
    step();
    idle();
    expect_read("sb_write_next", 1, 0, 32'h77, 1'b0);
    step();
    reserve(7);
    set_write(1, 7, 32'h78);
    expect_read("sb_both_same", 0, 0, 32'h78, 1'b0);
    step();
    idle();
    expect_read("sb_both_next_nb", 1, 0, 32'h78, 1'b1);
    expect_read("sb_both_next_bp", 0, 0, 32'h78, 1'b1);

    // Asynchronous reset between clock edges.
    step();
    set_reads(7, 5);
    expect_read("pre_reset_p0", 0, 0, 32'h78, 1'b1);
    expect_read("pre_reset_p1", 0, 1, 32'h22, 1'b0);
    step();
    reset_n = 1'b0;
    expect_read("async_reset_p0", 0, 0, 32'd0, 1'b0);
    expect_read("async_reset_p1", 0, 1, 32'd0, 1'b0);
    expect_read("async_reset_nb", 1, 0, 32'd0, 1'b0);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    step();
    set_reads(7, 3);
    expect_read("post_reset_p0", 0, 0, 32'd0, 1'b0);
    expect_read("post_reset_p1", 1, 1, 32'd0, 1'b0);

    // Let the monitor drain, bounded.
    step();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clock);
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
